// File: rtl/reg_file_pkg.sv
// Shared register-file constants: default widths and the hard-wired zero register.
// Pure declarations; no timing or flow control.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard with a registered busy count and per-port busy lookup.
// Busy bits and count update at the clock edge; rd_busy is combinational; no backpressure.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              wr_fire, rsv_fire;
  logic [ADDR_W-1:0] ra;

  always_comb begin
    wr_fire  = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
    rsv_fire = rsv_en && (rsv_addr != ADDR_W'(REG_ZERO));
    busy_d   = busy_q;
    // Clear before set so a same-edge reserve (the newer producer) wins.
    if (wr_fire) busy_d[wr_addr] = 1'b0;
    if (rsv_fire) busy_d[rsv_addr] = 1'b1;
    busy_cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      // A write landing this cycle satisfies the reader when forwarding is on.
      rd_busy[i] = busy_q[ra] && !((BYPASS != 0) && wr_fire && (wr_addr == ra));
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zero register, optional write forwarding and busy scoreboard.
// Reads are zero-latency combinational, writes land at the clock edge; no backpressure.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_fire;
  logic              byp_ok;
  logic [ADDR_W-1:0] ra;

  always_comb begin
    wr_fire = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
    // Forwarding is suppressed in reset so outputs read 0 while the array is cleared.
    byp_ok  = wr_fire && rst && (BYPASS != 0);
    mem_d   = mem_q;
    if (wr_fire) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= mem_d[r];
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*DATA_W +: DATA_W] = (byp_ok && (wr_addr == ra)) ? wr_data : mem_q[ra];
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: forwarding and non-forwarding instances checked against an array model.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic [NR-1:0] rd_busy, rd_busy_nb;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic [AW:0]   busy_cnt, busy_cnt_nb;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy [DEPTH];

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_nb)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural model: an array of values and an array of busy flags.
  initial begin
    for (int r = 0; r < DEPTH; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_reg[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic bit same_write(input int ra);
    return rst && wr_en && (wr_addr != 0) && (int'(wr_addr) == ra);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int ra, input bit byp);
    if (byp && same_write(ra)) return wr_data;
    return m_reg[ra];
  endfunction

  function automatic bit exp_busy(input int ra, input bit byp);
    return m_busy[ra] && !(byp && same_write(ra));
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(m_busy[r]);
    return (AW+1)'(n);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int p = 0; p < NR; p++) begin
        int ra;
        ra = int'(rd_addr[p*AW +: AW]);
        chk($sformatf("m_rd_data%0d_a%0d", p, ra), rd_data[p*DW +: DW], exp_data(ra, 1'b1));
        chk($sformatf("m_rd_busy%0d_a%0d", p, ra), rd_busy[p], exp_busy(ra, 1'b1));
        chk($sformatf("m_nb_rd_data%0d_a%0d", p, ra), rd_data_nb[p*DW +: DW], exp_data(ra, 1'b0));
        chk($sformatf("m_nb_rd_busy%0d_a%0d", p, ra), rd_busy_nb[p], exp_busy(ra, 1'b0));
      end
      chk("m_busy_cnt", busy_cnt, exp_cnt());
      chk("m_nb_busy_cnt", busy_cnt_nb, exp_cnt());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    // Reset held while a write is presented.
    set_rd(5, 2);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd32;
    tick(); cmp_en = 1'b1;
    tick(); tick();
    settle();
    chk("rst_hold_rd5", rd_data[DW-1:0], 32'd0);
    chk("rst_hold_cnt", busy_cnt, 6'd0);
    idle();
    rst = 1'b1;
    settle();
    chk("rst_rel_rd5", rd_data[DW-1:0], 32'd0);
    chk("rst_rel_cnt", busy_cnt, 6'd0);

    // Basic write/read and zero register.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd32;
    tick();
    wr_addr = 5'd2; wr_data = 32'd50;
    tick();
    idle();
    settle();
    chk("rd_r5", rd_data[DW-1:0], 32'd32);
    chk("rd_r2", rd_data[2*DW-1:DW], 32'd50);
    set_rd(0, 0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd7;
    settle();
    chk("r0_byp", rd_data[DW-1:0], 32'd0);
    tick();
    idle();
    settle();
    chk("r0_after", rd_data[DW-1:0], 32'd0);
    chk("r0_after_nb", rd_data_nb[DW-1:0], 32'd0);

    // Same-cycle forwarding.
    set_rd(5, 2);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd99;
    settle();
    chk("byp_on", rd_data[DW-1:0], 32'd99);
    chk("byp_off", rd_data_nb[DW-1:0], 32'd32);
    tick();
    idle();
    settle();
    chk("byp_after", rd_data[DW-1:0], 32'd99);
    chk("byp_after_nb", rd_data_nb[DW-1:0], 32'd99);

    // Scoreboard set and clear.
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idle();
    set_rd(3, 3);
    settle();
    chk("sb_busy", rd_busy, 2'b11);
    chk("sb_cnt1", busy_cnt, 6'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd11;
    settle();
    chk("sb_mask_on", rd_busy, 2'b00);
    chk("sb_mask_off", rd_busy_nb, 2'b11);
    tick();
    idle();
    settle();
    chk("sb_clr_busy", rd_busy, 2'b00);
    chk("sb_clr_cnt", busy_cnt, 6'd0);
    chk("sb_r3", rd_data[DW-1:0], 32'd11);

    // Reserve and write to the same register on one edge.
    rsv_en = 1'b1; rsv_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd8;
    tick();
    idle();
    set_rd(4, 0);
    settle();
    chk("col_r4", rd_data[DW-1:0], 32'd8);
    chk("col_busy", rd_busy[0], 1'b1);
    chk("col_busy_r0", rd_busy[1], 1'b0);
    chk("col_cnt", busy_cnt, 6'd1);

    // Re-reserve a busy register; write a non-busy one.
    rsv_en = 1'b1; rsv_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hdead_beef;
    tick();
    idle();
    set_rd(4, 6);
    settle();
    chk("rersv_cnt", busy_cnt, 6'd1);
    chk("wr_nonbusy", rd_data[2*DW-1:DW], 32'hdead_beef);
    chk("wr_nonbusy_busy", rd_busy[1], 1'b0);

    // Fill the scoreboard, then reset mid-operation.
    for (int a = 1; a < DEPTH; a++) begin
      rsv_en = 1'b1; rsv_addr = AW'(a);
      tick();
    end
    idle();
    settle();
    chk("full_cnt", busy_cnt, 6'd31);
    rsv_en = 1'b1; rsv_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd5;
    rst = 1'b0;
    tick();
    idle();
    rst = 1'b1;
    settle();
    chk("mid_rst_cnt", busy_cnt, 6'd0);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a);
      #1;
      chk($sformatf("mid_rst_rd_a%0d", a), rd_data, '0);
      chk($sformatf("mid_rst_busy_a%0d", a), rd_busy, 2'b00);
    end

    // First edge after release takes a write and a reserve.
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd123;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    tick();
    idle();
    set_rd(9, 10);
    settle();
    chk("post_rst_r9", rd_data[DW-1:0], 32'd123);
    chk("post_rst_busy10", rd_busy[1], 1'b1);
    chk("post_rst_cnt", busy_cnt, 6'd1);

    // Mixed traffic covered by the model on every cycle.
    for (int k = 0; k < 40; k++) begin
      wr_en    = (k % 3) != 0;
      wr_addr  = AW'((k * 7) % DEPTH);
      wr_data  = DW'(k * 1000 + k);
      rsv_en   = (k % 2) == 0;
      rsv_addr = AW'((k * 5 + 3) % DEPTH);
      set_rd(k % DEPTH, (k * 7) % DEPTH);
      tick();
    end
    idle();
    tick();
    tick();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL take parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL take parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL take parameter NUM_RD, default 2, number of independent read ports.
REQ-004 SHALL take parameter BYPASS, default 1; 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst as elsewhere in the datapath.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-008 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W].
REQ-010 rd_busy  output  NUM_RD  per port: 1 = addressed register has a pending producer.
REQ-011 wr_en  input  1  write strobe.
REQ-012 wr_addr  input  ADDR_W  write address.
REQ-013 wr_data  input  DATA_W  write data.
REQ-014 rsv_en  input  1  reserve strobe; marks rsv_addr busy (instruction issued and awaiting writeback).
REQ-015 rsv_addr  input  ADDR_W  register to reserve.
REQ-016 busy_cnt  output  ADDR_W+1  number of registers currently marked busy.

Function
REQ-017 Reads SHALL be combinational; rd_data[i] = reg[rd_addr[i]] with zero-cycle latency.
REQ-018 Register 0 SHALL read as 0 always; writes and reserves to address 0 are ignored; rd_busy for address 0 is always 0.
REQ-019 On a rising clk with wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data; the value is visible in the register array from the next cycle.
REQ-020 If BYPASS=1, wr_en=1, and wr_addr==rd_addr[i]!=0, rd_data[i] SHALL equal wr_data in the same cycle; if BYPASS=0, it SHALL show the old value.
REQ-021 The scoreboard SHALL keep one busy bit per register: set by rsv_en at the clock edge, cleared by wr_en to the same address at the clock edge.
REQ-022 Simultaneous rsv_en and wr_en to the same address SHALL leave the bit set (the new producer wins).
REQ-023 rd_busy[i] SHALL be busy[rd_addr[i]], masked to 0 when BYPASS=1 and a same-cycle write to that address is present.
REQ-024 Reserving an already-busy register SHALL keep it busy with no error; writing a non-busy register SHALL write data and leave the bit 0.
REQ-025 busy_cnt SHALL be registered and consistent with the busy bits after every edge; range 0..DEPTH-1.
REQ-026 All read ports SHALL behave identically; any number of ports may address the same register.

Reset
REQ-027 While rst=0, asynchronously, all registers SHALL be 0, all busy bits 0, and busy_cnt 0; rd_data and rd_busy therefore read 0.
REQ-028 Reset asserted mid-operation SHALL discard pending writes and reserves in that cycle; there is no partial update.
REQ-029 After rst deasserts, the first rising edge SHALL accept writes and reserves normally.

Structure
REQ-030 A shared package reg_file_pkg SHALL hold the default DATA_W/ADDR_W constants and the register-0 address constant used across the datapath.
REQ-031 The scoreboard (busy bits, busy_cnt, rd_busy masking) SHALL be one sub-module named reg_scoreboard; the data array and bypass logic stay in reg_file_mp.

Verification
REQ-032 Reset: hold rst=0 while driving wr_en=1, wr_addr=5, wr_data=32 -> rd_data(addr 5)=0, busy_cnt=0 after release.
REQ-033 Write/read: write 32 to r5, then 50 to r2; read R1=5, R2=2 -> 32 and 50; write 7 to r0 -> r0 reads 0.
REQ-034 Bypass: same cycle wr r5=99 with rd_addr[0]=5 -> rd_data[0]=99 with BYPASS=1, previous value with BYPASS=0.
REQ-035 Scoreboard: rsv r3 -> rd_busy=1 and busy_cnt=1; wr r3=11 -> rd_busy=0, busy_cnt=0, r3 reads 11.
REQ-036 Collision: rsv r4 and wr r4=8 in the same cycle -> r4 reads 8, busy stays 1, busy_cnt=1.
REQ-037 Reset mid-op: reserve r1 through r31, assert rst for one cycle -> all registers 0, busy_cnt=0, all rd_busy 0.
